oqpsk_chip_tx: RTL

Transmit-side chip timing and spreading block for the 802.15.4 O-QPSK path, the counterpart of the receive CDR decision counter. It accepts 4-bit data symbols over a valid/ready handshake and maps each one to its 32-chip PN sequence. Chips are issued at one chip per i_nb_P clock cycles: even chips go to the I rail and odd chips to the Q rail, which produces the half-chip I/Q offset. It feeds the half-sine pulse shaper.

---
 rtl/oqpsk_chip_tx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/oqpsk_chip_tx.sv
// O-QPSK transmit spreader: maps 4-bit symbols to 32-chip PN sequences and
// issues one chip every P cycles, even chips on I and odd chips on Q.
module oqpsk_chip_tx (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_nb_P,
  input  logic [3:0] i_sym,
  input  logic       i_sym_valid,
  output logic       o_sym_ready,
  output logic       o_chip_i,
  output logic       o_chip_q,
  output logic       o_chip_stb,
  output logic [4:0] o_chip_idx,
  output logic       o_active
);

  // Symbol 0 with chip c0 in the MSB.
  localparam logic [31:0] SYM0 = 32'hD9C3_522E;

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  per_q, per_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] seq_q, seq_d;
  logic        tick_d;
  logic        accept;
  logic        chip_i_q, chip_q_q, stb_q;
  logic [4:0]  chip_idx_q;

  function automatic logic [31:0] chip_seq(input logic [3:0] sym);
    logic [63:0] dbl;
    logic [31:0] rot;
    dbl = {SYM0, SYM0} >> {sym[2:0], 2'b00};
    rot = dbl[31:0];
    // Upper eight symbols invert the odd chips (c1, c3, ...).
    chip_seq = sym[3] ? (rot ^ 32'h5555_5555) : rot;
  endfunction

  assign o_sym_ready = (state_q == IDLE) || ((idx_q == 5'd31) && (cnt_q == per_q - 6'd1));
  assign accept      = i_sym_valid && o_sym_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          seq_d   = chip_seq(i_sym);
          per_d   = (i_nb_P < 6'd2) ? 6'd2 : i_nb_P;
          cnt_d   = 6'd0;
          idx_d   = 5'd0;
          state_d = SEND;
          tick_d  = 1'b1;
        end
      end
      SEND: begin
        if (cnt_q == per_q - 6'd1) begin
          cnt_d = 6'd0;
          if (idx_q == 5'd31) begin
            idx_d = 5'd0;
            if (accept) begin
              seq_d  = chip_seq(i_sym);
              tick_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d  = idx_q + 5'd1;
            tick_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      per_q   <= 6'd2;
      idx_q   <= 5'd0;
      seq_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
    end
  end

  // Outputs are loaded on the edge entering a counter==0 cycle so the chip
  // lands exactly on its tick cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      chip_i_q   <= 1'b0;
      chip_q_q   <= 1'b0;
      stb_q      <= 1'b0;
      chip_idx_q <= 5'd0;
    end else begin
      stb_q <= tick_d;
      if (tick_d) begin
        chip_idx_q <= idx_d;
        if (idx_d[0]) chip_q_q <= seq_d[~idx_d];
        else          chip_i_q <= seq_d[~idx_d];
      end
    end
  end

  assign o_chip_i   = chip_i_q;
  assign o_chip_q   = chip_q_q;
  assign o_chip_stb = stb_q;
  assign o_chip_idx = chip_idx_q;
  assign o_active   = (state_q == SEND);

endmodule
